rom_scan_ctrl: RTL and testbench

- Sequencer that drives a synchronous single-port ROM with 1-cycle read latency and an active-low read enable.
- Steps the ROM address through a programmable window [addr_lo, addr_hi], either one word per step-button press or automatically at a prescaled rate.
- Captures each returned word into a holding register that feeds the 7-segment display path.
- Sits between the board buttons/switches and the ROM instance.

---
 rtl/rom_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_rom_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_scan_ctrl.sv
// ROM address sequencer: steps a 1-cycle-latency ROM through [addr_lo, addr_hi]
// on a button press or a prescaled auto-scan tick, and holds the last word read.
module rom_scan_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int TICK_DIV      = 50000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     btn_step_n,
  input  logic                     btn_run_n,
  input  logic [ADDRESS_WIDTH-1:0] addr_lo,
  input  logic [ADDRESS_WIDTH-1:0] addr_hi,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  output logic                     rom_rd_n,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     running,
  output logic                     wrap
);

  localparam int PRESCALE_W = $clog2(TICK_DIV);
  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, READ, LATCH} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0]   step_sync, run_sync;
  logic                     step_prev, run_prev;
  logic                     step_edge, run_edge;
  logic                     step_pending, run_pending, run_req;
  logic [PRESCALE_W-1:0]    prescaler;
  logic                     tick;
  logic [ADDRESS_WIDTH-1:0] ptr, eff_hi, start_addr;
  logic                     in_window, at_hi, accept;

  // Button synchronizers and falling-edge detectors run every clk, independent of ce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_sync <= '1;
      run_sync  <= '1;
      step_prev <= 1'b1;
      run_prev  <= 1'b1;
    end else begin
      step_sync <= {step_sync[SYNC_STAGES-2:0], btn_step_n};
      run_sync  <= {run_sync[SYNC_STAGES-2:0], btn_run_n};
      step_prev <= step_sync[SYNC_STAGES-1];
      run_prev  <= run_sync[SYNC_STAGES-1];
    end
  end

  assign step_edge = step_prev & ~step_sync[SYNC_STAGES-1];
  assign run_edge  = run_prev & ~run_sync[SYNC_STAGES-1];
  assign run_req   = run_edge | run_pending;

  // An inverted window collapses to the single address addr_lo
  assign eff_hi     = (addr_lo > addr_hi) ? addr_lo : addr_hi;
  assign in_window  = (ptr >= addr_lo) && (ptr <= eff_hi);
  assign start_addr = in_window ? ptr : addr_lo;
  assign at_hi      = (ptr == eff_hi);

  // A pending toggle swallows the tick of the cycle it is applied in
  assign tick = ce & running & ~run_req & (prescaler == TICK_LAST);

  // Run toggle and prescaler; a run edge seen while ce=0 waits in run_pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running     <= 1'b0;
      run_pending <= 1'b0;
      prescaler   <= '0;
    end else if (ce) begin
      if (run_req) begin
        running     <= ~running;
        run_pending <= 1'b0;
        prescaler   <= '0;
      end else if (running) begin
        prescaler <= (prescaler == TICK_LAST) ? '0 : prescaler + PRESCALE_W'(1);
      end
    end else if (run_edge) begin
      run_pending <= 1'b1;
    end
  end

  // Acceptance wins over a same-cycle edge so a burst collapses into one read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_pending <= 1'b0;
    end else if (accept) begin
      step_pending <= 1'b0;
    end else if (step_edge) begin
      step_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rom_rd_n   = 1'b1;
    data_valid = 1'b0;
    wrap       = 1'b0;
    if (ce) begin
      unique case (state)
        IDLE: begin
          if (step_pending || tick) begin
            accept     = 1'b1;
            state_next = READ;
          end
        end
        READ: begin
          rom_rd_n   = 1'b0;
          state_next = LATCH;
        end
        LATCH: begin
          data_valid = 1'b1;
          wrap       = at_hi;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Address pointer, ROM address register and output holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      rom_addr <= '0;
      data_out <= '0;
    end else if (accept) begin
      ptr      <= start_addr;
      rom_addr <= start_addr;
    end else if (data_valid) begin
      data_out <= rom_data;
      ptr      <= at_hi ? addr_lo : ptr + ADDRESS_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Scoreboard bench for rom_scan_ctrl: directed button/ce/reset sequences push
// expected ROM reads; a monitor pops and compares on every data_valid.
module tb_rom_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        btn_step_n;
  logic        btn_run_n;
  logic [7:0]  addr_lo;
  logic [7:0]  addr_hi;
  logic [7:0]  rom_addr;
  logic        rom_rd_n;
  logic [15:0] rom_data;
  logic [15:0] data_out;
  logic        data_valid;
  logic        running;
  logic        wrap;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        wrap;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        mon_wrap;
  logic [7:0]  mon_addr;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_seen;
  int          run_valid_k[4] = '{8, 12, 16, 20};

  rom_scan_ctrl #(
    .DATA_WIDTH(16),
    .ADDRESS_WIDTH(8),
    .TICK_DIV(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .btn_step_n(btn_step_n),
    .btn_run_n(btn_run_n),
    .addr_lo(addr_lo),
    .addr_hi(addr_hi),
    .rom_addr(rom_addr),
    .rom_rd_n(rom_rd_n),
    .rom_data(rom_data),
    .data_out(data_out),
    .data_valid(data_valid),
    .running(running),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  // ROM contents: mem[i] = i + 0x100, one-cycle registered read
  always @(posedge clk) begin
    if (!rom_rd_n) rom_data <= 16'h0100 + {8'h00, rom_addr};
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("[TB] FAIL %s: got timeout expected data_valid", name);
  endtask

  task automatic expect_read(input logic [7:0] a, input logic [15:0] d, input logic w);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  // One step press from a negedge; data_valid is due 5 cycles later
  task automatic apply_stimulus(input logic [7:0] a, input logic [15:0] d, input logic w);
    bit seen;
    expect_read(a, d, w);
    seen = 1'b0;
    btn_step_n = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (k == 3) btn_step_n = 1'b1;
      if (data_valid) begin
        seen = 1'b1;
        check_output("step_latency", k, 5);
      end
    end
    btn_step_n = 1'b1;
    if (!seen) fail_timeout("step_latency");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valids(input int n, input int budget);
    int cnt;
    cnt = 0;
    for (int k = 0; k < budget && cnt < n; k++) begin
      @(negedge clk);
      if (data_valid) cnt++;
    end
    if (cnt < n) fail_timeout("wait_valids");
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every data_valid pops one expected read; data_out is checked after the edge
  initial begin
    forever begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        mon_wrap = wrap;
        mon_addr = rom_addr;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL unexpected_valid: got read of 0x%0h expected none", rom_addr);
        end else begin
          mon_e = exp_q.pop_front();
          @(posedge clk);
          #1;
          check_output("read_addr", mon_addr, mon_e.addr);
          check_output("read_wrap", mon_wrap, mon_e.wrap);
          check_output("data_out", data_out, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    ce         = 1'b1;
    btn_step_n = 1'b1;
    btn_run_n  = 1'b1;
    addr_lo    = 8'd0;
    addr_hi    = 8'd3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_data_out", data_out, 0);
    check_output("reset_rom_addr", rom_addr, 0);
    check_output("reset_rom_rd_n", rom_rd_n, 1);
    check_output("reset_running", running, 0);
    check_output("reset_valid", data_valid, 0);
    check_output("reset_wrap", wrap, 0);

    $display("[TB] manual stepping through window 0..3");
    apply_stimulus(8'd0, 16'h0100, 1'b0);
    apply_stimulus(8'd1, 16'h0101, 1'b0);
    apply_stimulus(8'd2, 16'h0102, 1'b0);
    apply_stimulus(8'd3, 16'h0103, 1'b1);
    apply_stimulus(8'd0, 16'h0100, 1'b0);

    $display("[TB] auto-scan window 10..12");
    addr_lo = 8'd10;
    addr_hi = 8'd12;
    @(negedge clk);
    expect_read(8'd10, 16'h010A, 1'b0);
    expect_read(8'd11, 16'h010B, 1'b0);
    expect_read(8'd12, 16'h010C, 1'b1);
    expect_read(8'd10, 16'h010A, 1'b0);
    n_seen = 0;
    btn_run_n = 1'b0;
    for (int k = 1; k <= 60 && n_seen < 4; k++) begin
      @(negedge clk);
      if (k == 3) btn_run_n = 1'b1;
      if (k == 4) check_output("running_on", running, 1);
      if (data_valid) begin
        check_output("run_valid_cycle", k, run_valid_k[n_seen]);
        n_seen++;
      end
    end
    if (n_seen < 4) fail_timeout("run_valids");
    btn_run_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_run_n = 1'b1;
    repeat (30) @(negedge clk);
    check_output("running_off", running, 0);
    check_output("run_queue_drained", exp_q.size(), 0);

    $display("[TB] ce stall in READ with a burst of step edges");
    expect_read(8'd11, 16'h010B, 1'b0);
    expect_read(8'd12, 16'h010C, 1'b1);
    btn_step_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_step_n = 1'b1;
    @(negedge clk);
    check_output("stall_read_rd_n", rom_rd_n, 0);
    check_output("stall_read_addr", rom_addr, 8'd11);
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      btn_step_n = 1'b0;
      @(negedge clk);
      btn_step_n = 1'b1;
    end
    repeat (4) @(negedge clk);
    check_output("stall_rom_addr", rom_addr, 8'd11);
    check_output("stall_rd_n", rom_rd_n, 1);
    check_output("stall_data_out", data_out, 16'h010A);
    check_output("stall_valid", data_valid, 0);
    ce = 1'b1;
    wait_valids(2, 30);
    check_output("stall_queue_drained", exp_q.size(), 0);
    apply_stimulus(8'd10, 16'h010A, 1'b0);

    $display("[TB] inverted window 20..5");
    addr_lo = 8'd20;
    addr_hi = 8'd5;
    @(negedge clk);
    apply_stimulus(8'd20, 16'h0114, 1'b1);
    apply_stimulus(8'd20, 16'h0114, 1'b1);

    $display("[TB] reset during LATCH");
    addr_lo = 8'd7;
    addr_hi = 8'd9;
    @(negedge clk);
    btn_step_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_step_n = 1'b1;
    @(negedge clk);
    check_output("rst_read_phase", rom_rd_n, 0);
    check_output("rst_read_addr", rom_addr, 8'd7);
    @(posedge clk);
    #1;
    check_output("rst_latch_phase", data_valid, 1);
    rst = 1'b1;
    #1;
    check_output("rst_data_out", data_out, 0);
    check_output("rst_rom_addr", rom_addr, 0);
    check_output("rst_running", running, 0);
    check_output("rst_valid", data_valid, 0);
    check_output("rst_wrap", wrap, 0);
    @(negedge clk);
    rst = 1'b0;
    addr_lo = 8'd0;
    addr_hi = 8'd9;
    @(negedge clk);
    apply_stimulus(8'd0, 16'h0100, 1'b0);
    check_output("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
